// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the quotient reported on a divide by zero.
package seq_divider32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Quotient reported when the divisor is zero (all ones).
    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider32_div_sub_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor with a WIDTH+1-bit ripple subtractor
// (a + ~b + 1) and keep the difference only if it did not go negative.
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   op_b_n;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   carry;

    // The partial remainder is always below 2^(WIDTH-1) before a shift, so
    // dropping its MSB loses nothing.
    assign shifted = {rem[WIDTH-2:0], in_bit};
    assign op_a    = {1'b0, shifted};
    assign op_b_n  = ~{1'b0, divisor};

    // Ripple subtract: each bit's carry-out feeds the next bit's carry-in.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, and
        // blocking '=' is used so later bits see this pass's carries; both
        // keep this a pure mux/adder network with no inferred latch.
        diff  = '0;
        carry = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]    = op_a[i] ^ op_b_n[i] ^ carry[i];
            carry[i+1] = (op_a[i] & op_b_n[i]) | (carry[i] & (op_a[i] ^ op_b_n[i]));
        end
        diff[WIDTH] = op_a[WIDTH] ^ op_b_n[WIDTH] ^ carry[WIDTH];
    end

    // Sign bit of the trial difference clear means the divisor fitted.
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted;

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// One quotient bit is produced per clock; a zero divisor completes in one
// clock with an all-ones quotient and the dividend as remainder.
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_reg),
        .in_bit   (q_reg[WIDTH-1]),
        .divisor  (d_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_next = {q_reg[WIDTH-2:0], q_bit};

    // Control FSM, iteration counter, working registers and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' so every register samples the values
            // from before this edge, independent of statement order.
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q_reg <= dividend;
                        r_reg <= '0;
                        d_reg <= divisor;
                        cnt   <= '0;
                        if (divisor != '0) begin
                            state       <= CALC;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end else begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= rem_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= rem_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed cases from the test plan,
// then randomized operands compared against plain '/' and '%' arithmetic.
module tb_seq_divider32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_vec   = 0;
    int n_fail  = 0;

    // Results the outputs are expected to hold between completions.
    logic [31:0] hold_q = '0;
    logic [31:0] hold_r = '0;

    seq_divider32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Called at a falling edge: present a request for exactly one rising edge.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Wait for done (lat0 rising edges already elapsed since acceptance),
    // checking hold behaviour on the way, then check latency and results.
    task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input int lat0);
        int lat = lat0;
        int exp_lat = (b == 0) ? 1 : 33;
        if (lat == 1) check({tag, "_busy"}, {31'd0, busy}, {31'd0, b != 0});
        while (done !== 1'b1 && lat < 40) begin
            check({tag, "_hold_q"}, quotient, hold_q);
            check({tag, "_hold_r"}, remainder, hold_r);
            check({tag, "_dz_calc"}, {31'd0, div_by_zero}, 32'd0);
            check({tag, "_busy_calc"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_q"}, quotient, ref_q(a, b));
        check({tag, "_r"}, remainder, ref_r(a, b));
        check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, b == 0});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        hold_q = ref_q(a, b);
        hold_r = ref_r(a, b);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_q"}, quotient, 32'd0);
        check({tag, "_r"}, remainder, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_dz"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // 100 / 7, then confirm done is a single-cycle pulse.
        pulse_start(32'd100, 32'd7);
        wait_done("d100_7", 32'd100, 32'd7, 1);
        @(negedge clk);
        check("d100_7_pulse", {31'd0, done}, 32'd0);
        check("d100_7_hold_q", quotient, 32'd14);

        // Extreme operands.
        pulse_start(32'hFFFF_FFFF, 32'd1);
        wait_done("dmax_1", 32'hFFFF_FFFF, 32'd1, 1);
        @(negedge clk);
        pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        pulse_start(32'd0, 32'd9);
        wait_done("d0_9", 32'd0, 32'd9, 1);
        @(negedge clk);

        // Divide by zero completes after a single edge with busy never high.
        pulse_start(32'd5, 32'd0);
        wait_done("d5_0", 32'd5, 32'd0, 1);
        @(negedge clk);
        check("d5_0_pulse", {31'd0, done}, 32'd0);
        check("d5_0_dz_hold", {31'd0, div_by_zero}, 32'd1);
        check("d5_0_busy_after", {31'd0, busy}, 32'd0);

        // Start re-asserted mid-calculation is ignored; start in the done
        // cycle is accepted back to back.
        pulse_start(32'd3, 32'd10);
        repeat (4) @(negedge clk);
        pulse_start(32'd50, 32'd5);
        wait_done("d3_10", 32'd3, 32'd10, 6);
        pulse_start(32'd50, 32'd5);
        wait_done("d50_5", 32'd50, 32'd5, 1);
        @(negedge clk);
        check("d50_5_pulse", {31'd0, done}, 32'd0);

        // Reset mid-operation abandons the division.
        pulse_start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        check_idle_outputs("mid_reset_hold");
        rst_n = 1'b1;
        hold_q = '0;
        hold_r = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("abandoned_no_done", {31'd0, done}, 32'd0);
        end
        check_idle_outputs("abandoned_idle");
        pulse_start(32'd1000, 32'd3);
        wait_done("d1000_3", 32'd1000, 32'd3, 1);
        @(negedge clk);

        // Randomized operands, launched back to back from the done cycle;
        // operand inputs are scrambled after acceptance.
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = '0;
                1: begin b = $urandom | 32'h1; a = b - 32'($urandom_range(1, 100)); end
                2: b = 32'($urandom_range(1, 255));
                3: a = '0;
                4: b = 32'd1;
                default: ;
            endcase
            if (sel == 1 && b < 32'd101) a = b - 32'd1;
            pulse_start(a, b);
            dividend = $urandom;
            divisor  = $urandom;
            wait_done($sformatf("rnd%0d", i), a, b, 1);
        end
        @(negedge clk);
        check("final_pulse", {31'd0, done}, 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
